stopwatch_timer: RTL and testbench
==================================

Name: stopwatch_timer

Overview:
- Parametrised successor to the fixed-function stopwatch counter.
- Keeps the 8-digit BCD time base (hh:mm:ss.cc) and adds up/down mode, a preset load with validity checking, and lap capture.
- Adds wrap and expiry flags plus a configurable prescaler and hour limit.
- Sits between the board clock and the 7-segment display mux; o_time and o_lap feed the display select logic directly.

Parameters:
- CLK_DIV, 500000: i_clk cycles per 1/100 s tick (500000 for 50 MHz; set to 5 in simulation).
- DIV_WIDTH, 19: prescaler width; must satisfy 2**DIV_WIDTH >= CLK_DIV.
- HR_MAX, 99: maximum hour value, 1..99 (for example 23 for time-of-day style wrap).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_sclr  in  1  synchronous clear of time, lap, flags and prescaler.
- i_en  in  1  run enable; prescaler and time hold when low.
- i_mode  in  1  0 = count up (stopwatch), 1 = count down (timer).
- i_load  in  1  one-cycle strobe: load i_load_val into time.
- i_load_val  in  32  BCD preset, same digit layout as o_time.
- i_lap  in  1  one-cycle strobe: capture current time into o_lap.
- o_time  out  32  live BCD time. Digit layout:
  - [3:0] hundredths, [7:4] tenths
  - [11:8] sec units, [15:12] sec tens
  - [19:16] min units, [23:20] min tens
  - [27:24] hr units, [31:28] hr tens
- o_lap  out  32  captured lap time, same layout.
- o_lap_valid  out  1  high once a lap has been captured.
- o_wrap  out  1  one-cycle pulse when an up count wraps HR_MAX:59:59.99 -> 0.
- o_done  out  1  one-cycle pulse when a down count reaches 00:00:00.00.
- o_expired  out  1  level; high while in down mode with time at zero after o_done.
- o_load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (i_rst high, asynchronous): all outputs and the prescaler clear to 0 immediately.
- Priority at each rising edge: i_sclr > i_load > tick/lap. Lap capture is evaluated alongside the tick.
- Prescaler:
  - Counts 0..CLK_DIV-1 while i_en=1, holds while i_en=0.
  - Tick asserts internally in the cycle the count equals CLK_DIV-1; count then returns to 0.
  - First tick after clear therefore lands CLK_DIV cycles after i_en rises.
- Up count, on each tick:
  - Hundredths roll 00..99, seconds 00..59, minutes 00..59, hours 00..HR_MAX.
  - Each roll-over carries into the next field.
  - At HR_MAX:59:59.99 the next value is all zeros and o_wrap pulses for one cycle.
- Down count, on each tick:
  - Decrement with borrow; a field at 0 borrows and reloads to 99/59/59.
  - Tick that yields all zeros: o_done pulses one cycle and o_expired sets.
  - Ticks at zero in down mode leave time unchanged.
  - o_expired clears on i_sclr, i_load, i_mode=0 or reset.
- i_mode change takes effect on the next tick; the prescaler is unaffected.
- Load:
  - Accepted only if every digit is within range: hundredths/tenths/sec units/min units <=9, sec tens/min tens <=5, hours <=HR_MAX.
  - Accepted load: time takes i_load_val next cycle and the prescaler clears to 0.
  - Rejected load: time and prescaler unchanged; o_load_err pulses.
  - Load cancels a tick in the same cycle.
- Lap:
  - i_lap copies the o_time value present at that edge (pre-tick value) into o_lap and sets o_lap_valid.
  - Lap works whether i_en is high or low.
  - i_lap coincident with i_sclr: sclr wins, o_lap=0 and o_lap_valid=0.
  - i_lap coincident with an accepted i_load: lap captures the pre-load time.
- i_sclr: time, lap, o_lap_valid, o_expired and prescaler clear to 0; pulses stay low.
- All flags are registered; latency from tick to o_time, o_wrap or o_done is 1 cycle.

Decomposition:
- stopwatch_pkg holds:
  - digit-field index localparams (HUND_LO, SEC_U_LO, ...)
  - field limits (59, 99)
  - a BCD validity function shared with the bench scoreboard
- Sub-module stopwatch_prescaler (parameters CLK_DIV, DIV_WIDTH; ports i_clk, i_rst, i_sclr, i_en, i_restart; output o_tick).
- The BCD cascade stays in stopwatch_timer.

Test Plan (all with CLK_DIV=5, HR_MAX=99):
- Up count: i_rst pulse, then i_en=1 for 500 clocks -> o_time=32'h00000100 (1.00 s); no o_wrap.
- Up wrap: load 32'h99595999, i_mode=0, run 1 tick -> o_time=0 and o_wrap high exactly 1 cycle.
  - Rerun with HR_MAX=23: load 32'h23595999 gives the same result.
- Down expiry: load 32'h00000003, i_mode=1, run 3 ticks -> o_time=0, o_done 1-cycle pulse, o_expired=1.
  - 5 further ticks: o_time stays 0 and no new o_done.
- Lap on tick: i_lap in the same cycle as the tick taking 00000042 -> 00000043 -> o_lap=32'h00000042, o_lap_valid=1, o_time=32'h00000043.
- Invalid load: i_load_val=32'h00006000 (sec tens=6) while o_time=32'h00000010 -> o_load_err pulse, o_time stays 32'h00000010.
- Async reset and priority:
  - Assert i_rst between clock edges mid-prescaler -> all outputs 0 before the next edge.
  - Then i_sclr and i_load together -> o_time=0 and no o_load_err.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch/timer: digit positions, field limits
// and the preset validity check.
package stopwatch_pkg;
   localparam int HUND_LO  = 0;
   localparam int TENTH_LO = 4;
   localparam int SEC_U_LO = 8;
   localparam int SEC_T_LO = 12;
   localparam int MIN_U_LO = 16;
   localparam int MIN_T_LO = 20;
   localparam int HR_U_LO  = 24;
   localparam int HR_T_LO  = 28;

   localparam logic [7:0] CS_MAX = 8'h99;
   localparam logic [7:0] MS_MAX = 8'h59;

   function automatic logic f_bcd_valid(input logic [31:0] v, input int hr_max);
      logic ok;
      int   hr;
      ok = (v[HUND_LO  +: 4] <= 4'd9) && (v[TENTH_LO +: 4] <= 4'd9) &&
           (v[SEC_U_LO +: 4] <= 4'd9) && (v[SEC_T_LO +: 4] <= 4'd5) &&
           (v[MIN_U_LO +: 4] <= 4'd9) && (v[MIN_T_LO +: 4] <= 4'd5) &&
           (v[HR_U_LO  +: 4] <= 4'd9) && (v[HR_T_LO  +: 4] <= 4'd9);
      hr = int'(v[HR_T_LO +: 4]) * 10 + int'(v[HR_U_LO +: 4]);
      return ok && (hr <= hr_max);
   endfunction
endpackage

// File: rtl/stopwatch_if.sv
// Control and display bus between the board logic and the stopwatch core.
interface stopwatch_if;
   logic        i_sclr;
   logic        i_en;
   logic        i_mode;
   logic        i_load;
   logic [31:0] i_load_val;
   logic        i_lap;
   logic [31:0] o_time;
   logic [31:0] o_lap;
   logic        o_lap_valid;
   logic        o_wrap;
   logic        o_done;
   logic        o_expired;
   logic        o_load_err;

   modport master (output i_sclr, i_en, i_mode, i_load, i_load_val, i_lap,
                   input  o_time, o_lap, o_lap_valid, o_wrap, o_done, o_expired, o_load_err);
   modport slave  (input  i_sclr, i_en, i_mode, i_load, i_load_val, i_lap,
                   output o_time, o_lap, o_lap_valid, o_wrap, o_done, o_expired, o_load_err);
endinterface

// File: rtl/stopwatch_prescaler.sv
// Divides i_clk down to the 1/100 s tick; the tick is the last count of each period.
module stopwatch_prescaler #(
   parameter int CLK_DIV   = 500000,
   parameter int DIV_WIDTH = 19
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sclr,
   input  logic i_en,
   input  logic i_restart,
   output logic o_tick
);
   localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(CLK_DIV - 1);

   logic [DIV_WIDTH-1:0] r_cnt;
   logic                 w_last;

   assign w_last = (r_cnt == LAST);
   assign o_tick = i_en & w_last;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                  r_cnt <= '0;
      else if (i_sclr | i_restart) r_cnt <= '0;
      else if (i_en)              r_cnt <= w_last ? '0 : r_cnt + 1'b1;
   end
endmodule

// File: rtl/stopwatch_timer.sv
// BCD hh:mm:ss.cc stopwatch / countdown timer with preset load, lap capture and
// wrap/expiry flags.
module stopwatch_timer
   import stopwatch_pkg::*;
#(
   parameter int CLK_DIV   = 500000,
   parameter int DIV_WIDTH = 19,
   parameter int HR_MAX    = 99
) (
   input  logic           i_clk,
   input  logic           i_rst,
   stopwatch_if.slave     io_sw
);
   localparam logic [7:0] HR_BCD = {4'(HR_MAX / 10), 4'(HR_MAX % 10)};

   logic [31:0] r_time, r_lap;
   logic        r_lap_valid, r_wrap, r_done, r_expired, r_load_err;
   logic        w_tick, w_valid, w_load_ok, w_pre_en;
   logic [7:0]  w_cs, w_sec, w_min, w_hr;
   logic        w_c0, w_c1, w_c2, w_up_wrap, w_b0, w_b1, w_b2, w_zero;
   logic [31:0] w_up, w_dn;

   function automatic logic [7:0] f_inc(input logic [7:0] v, input logic [7:0] lim);
      if (v == lim)         return 8'h00;
      if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] f_dec(input logic [7:0] v, input logic [7:0] lim);
      if (v == 8'h00)       return lim;
      if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   assign w_valid   = f_bcd_valid(io_sw.i_load_val, HR_MAX);
   assign w_load_ok = io_sw.i_load & w_valid;
   // A rejected load freezes the prescaler for that cycle as well as the time.
   assign w_pre_en  = io_sw.i_en & ~(io_sw.i_load & ~w_valid);

   stopwatch_prescaler #(.CLK_DIV(CLK_DIV), .DIV_WIDTH(DIV_WIDTH)) u_pre (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_sclr    (io_sw.i_sclr),
      .i_en      (w_pre_en),
      .i_restart (w_load_ok),
      .o_tick    (w_tick)
   );

   always_comb begin
      w_cs  = r_time[HUND_LO  +: 8];
      w_sec = r_time[SEC_U_LO +: 8];
      w_min = r_time[MIN_U_LO +: 8];
      w_hr  = r_time[HR_U_LO  +: 8];
      w_zero = (r_time == '0);

      w_c0 = (w_cs == CS_MAX);
      w_c1 = w_c0 && (w_sec == MS_MAX);
      w_c2 = w_c1 && (w_min == MS_MAX);
      w_up_wrap = w_c2 && (w_hr == HR_BCD);
      w_up = {w_c2 ? f_inc(w_hr, HR_BCD) : w_hr,
              w_c1 ? f_inc(w_min, MS_MAX) : w_min,
              w_c0 ? f_inc(w_sec, MS_MAX) : w_sec,
              f_inc(w_cs, CS_MAX)};

      w_b0 = (w_cs == 8'h00);
      w_b1 = w_b0 && (w_sec == 8'h00);
      w_b2 = w_b1 && (w_min == 8'h00);
      w_dn = {w_b2 ? f_dec(w_hr, HR_BCD) : w_hr,
              w_b1 ? f_dec(w_min, MS_MAX) : w_min,
              w_b0 ? f_dec(w_sec, MS_MAX) : w_sec,
              f_dec(w_cs, CS_MAX)};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_time <= '0; r_lap <= '0; r_lap_valid <= 1'b0;
         r_wrap <= 1'b0; r_done <= 1'b0; r_expired <= 1'b0; r_load_err <= 1'b0;
      end else begin
         r_wrap     <= 1'b0;
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
         if (io_sw.i_sclr) begin
            r_time <= '0; r_lap <= '0; r_lap_valid <= 1'b0; r_expired <= 1'b0;
         end else begin
            if (io_sw.i_lap) begin
               r_lap       <= r_time;
               r_lap_valid <= 1'b1;
            end
            if (!io_sw.i_mode) r_expired <= 1'b0;
            if (io_sw.i_load) begin
               r_expired <= 1'b0;
               if (w_valid) r_time     <= io_sw.i_load_val;
               else         r_load_err <= 1'b1;
            end else if (w_tick) begin
               if (!io_sw.i_mode) begin
                  r_time <= w_up;
                  r_wrap <= w_up_wrap;
               end else if (!w_zero) begin
                  r_time <= w_dn;
                  if (w_dn == '0) begin
                     r_done    <= 1'b1;
                     r_expired <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign io_sw.o_time      = r_time;
   assign io_sw.o_lap       = r_lap;
   assign io_sw.o_lap_valid = r_lap_valid;
   assign io_sw.o_wrap      = r_wrap;
   assign io_sw.o_done      = r_done;
   assign io_sw.o_expired   = r_expired;
   assign io_sw.o_load_err  = r_load_err;
endmodule

// File: tb/tb_stopwatch_timer.sv
// Scoreboard bench: stimulus queues expected snapshots, a negedge monitor pops and compares.
module tb_stopwatch_timer;
   import stopwatch_pkg::*;

   typedef struct {
      int          dut;
      string       name;
      logic [31:0] tm, lap;
      logic        lv, wrap, done, expd, lerr;
      int          nw, nd, nl;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stopwatch_if bus_a();
   stopwatch_if bus_b();

   stopwatch_timer #(.CLK_DIV(5), .DIV_WIDTH(3), .HR_MAX(99)) u_a (
      .i_clk(clk), .i_rst(rst), .io_sw(bus_a));
   stopwatch_timer #(.CLK_DIV(5), .DIV_WIDTH(3), .HR_MAX(23)) u_b (
      .i_clk(clk), .i_rst(rst), .io_sw(bus_b));

   exp_t q[$];
   logic sample_req = 1'b0;
   int   n_chk = 0, n_fail = 0;
   int   cw[2], cd[2], cl[2];
   int   ew[2], ed[2], el[2];

   exp_t        m_e;
   logic [31:0] a_tm, a_lap;
   logic        a_lv, a_wrap, a_done, a_exp, a_lerr;

   task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s.%s: got %h expected %h", nm, f, act, expv);
      end
   endtask

   // Pulse counters catch extra or stretched pulses between snapshots.
   always @(negedge clk) begin
      if (bus_a.o_wrap === 1'b1)     cw[0]++;
      if (bus_a.o_done === 1'b1)     cd[0]++;
      if (bus_a.o_load_err === 1'b1) cl[0]++;
      if (bus_b.o_wrap === 1'b1)     cw[1]++;
      if (bus_b.o_done === 1'b1)     cd[1]++;
      if (bus_b.o_load_err === 1'b1) cl[1]++;
      if (sample_req) begin
         if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard: sample with empty queue");
         end else begin
            m_e = q.pop_front();
            if (m_e.dut == 0) begin
               a_tm = bus_a.o_time; a_lap = bus_a.o_lap; a_lv = bus_a.o_lap_valid;
               a_wrap = bus_a.o_wrap; a_done = bus_a.o_done; a_exp = bus_a.o_expired;
               a_lerr = bus_a.o_load_err;
            end else begin
               a_tm = bus_b.o_time; a_lap = bus_b.o_lap; a_lv = bus_b.o_lap_valid;
               a_wrap = bus_b.o_wrap; a_done = bus_b.o_done; a_exp = bus_b.o_expired;
               a_lerr = bus_b.o_load_err;
            end
            cmp(m_e.name, "time",      a_tm,   m_e.tm);
            cmp(m_e.name, "lap",       a_lap,  m_e.lap);
            cmp(m_e.name, "lap_valid", {31'd0, a_lv},   {31'd0, m_e.lv});
            cmp(m_e.name, "wrap",      {31'd0, a_wrap}, {31'd0, m_e.wrap});
            cmp(m_e.name, "done",      {31'd0, a_done}, {31'd0, m_e.done});
            cmp(m_e.name, "expired",   {31'd0, a_exp},  {31'd0, m_e.expd});
            cmp(m_e.name, "load_err",  {31'd0, a_lerr}, {31'd0, m_e.lerr});
            cmp(m_e.name, "n_wrap",    cw[m_e.dut], m_e.nw);
            cmp(m_e.name, "n_done",    cd[m_e.dut], m_e.nd);
            cmp(m_e.name, "n_lerr",    cl[m_e.dut], m_e.nl);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk(input int d, input string nm, input logic [31:0] tm, input logic [31:0] lap,
                      input logic lv, input logic wrap, input logic done, input logic expd,
                      input logic lerr);
      exp_t e;
      e.dut = d; e.name = nm; e.tm = tm; e.lap = lap; e.lv = lv;
      e.wrap = wrap; e.done = done; e.expd = expd; e.lerr = lerr;
      e.nw = ew[d]; e.nd = ed[d]; e.nl = el[d];
      q.push_back(e);
      sample_req = 1'b1;
      @(negedge clk); #1;
      sample_req = 1'b0;
   endtask

   task automatic ld_a(input logic [31:0] v);
      bus_a.i_load = 1'b1; bus_a.i_load_val = v;
      step(1);
      bus_a.i_load = 1'b0;
   endtask

   task automatic ld_b(input logic [31:0] v);
      bus_b.i_load = 1'b1; bus_b.i_load_val = v;
      step(1);
      bus_b.i_load = 1'b0;
   endtask

   initial begin
      bus_a.i_sclr = 0; bus_a.i_en = 0; bus_a.i_mode = 0; bus_a.i_load = 0;
      bus_a.i_load_val = '0; bus_a.i_lap = 0;
      bus_b.i_sclr = 0; bus_b.i_en = 0; bus_b.i_mode = 0; bus_b.i_load = 0;
      bus_b.i_load_val = '0; bus_b.i_lap = 0;

      step(2);
      chk(0, "reset", 32'h0, 32'h0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      step(1);

      // 500 cycles at 5 cycles/tick = 100 hundredths
      bus_a.i_en = 1'b1; step(500); bus_a.i_en = 1'b0;
      chk(0, "up_1s", 32'h00000100, 32'h0, 0, 0, 0, 0, 0);

      ld_a(32'h00000010);
      chk(0, "load_ok", 32'h00000010, 32'h0, 0, 0, 0, 0, 0);
      ld_a(32'h00006000); el[0]++;
      chk(0, "load_bad", 32'h00000010, 32'h0, 0, 0, 0, 0, 1);
      step(1);
      chk(0, "lerr_1cyc", 32'h00000010, 32'h0, 0, 0, 0, 0, 0);

      ld_a(32'h00000042);
      bus_a.i_en = 1'b1; step(4);
      bus_a.i_lap = 1'b1; step(1); bus_a.i_lap = 1'b0; bus_a.i_en = 1'b0;
      chk(0, "lap_tick", 32'h00000043, 32'h00000042, 1, 0, 0, 0, 0);
      bus_a.i_lap = 1'b1; step(1); bus_a.i_lap = 1'b0;
      chk(0, "lap_idle", 32'h00000043, 32'h00000043, 1, 0, 0, 0, 0);

      ld_a(32'h99595999);
      bus_a.i_en = 1'b1; step(5); bus_a.i_en = 1'b0; ew[0]++;
      chk(0, "wrap", 32'h0, 32'h00000043, 1, 1, 0, 0, 0);
      step(1);
      chk(0, "wrap_1cyc", 32'h0, 32'h00000043, 1, 0, 0, 0, 0);

      ld_a(32'h00000003);
      bus_a.i_mode = 1'b1; bus_a.i_en = 1'b1;
      step(5);
      chk(0, "down_1", 32'h00000002, 32'h00000043, 1, 0, 0, 0, 0);
      step(10); ed[0]++;
      chk(0, "done", 32'h0, 32'h00000043, 1, 0, 1, 1, 0);
      step(25);
      chk(0, "hold_zero", 32'h0, 32'h00000043, 1, 0, 0, 1, 0);
      bus_a.i_en = 1'b0; bus_a.i_mode = 1'b0;
      step(1);
      chk(0, "exp_clr_mode", 32'h0, 32'h00000043, 1, 0, 0, 0, 0);

      ld_b(32'h99595999); el[1]++;
      chk(1, "hr_range", 32'h0, 32'h0, 0, 0, 0, 0, 1);
      ld_b(32'h23595999);
      bus_b.i_en = 1'b1; step(5); bus_b.i_en = 1'b0; ew[1]++;
      chk(1, "wrap23", 32'h0, 32'h0, 0, 1, 0, 0, 0);

      // Reset lands mid-cycle with the prescaler part-way through a period
      ld_a(32'h00000010);
      bus_a.i_en = 1'b1; step(2);
      #2 rst = 1'b1;
      chk(0, "async_rst", 32'h0, 32'h0, 0, 0, 0, 0, 0);
      step(1);
      rst = 1'b0; bus_a.i_en = 1'b0;

      ld_a(32'h00000010);
      bus_a.i_lap = 1'b1; step(1); bus_a.i_lap = 1'b0;
      bus_a.i_sclr = 1'b1; bus_a.i_lap = 1'b1;
      ld_a(32'h00006000);
      bus_a.i_sclr = 1'b0; bus_a.i_lap = 1'b0;
      chk(0, "sclr_prio", 32'h0, 32'h0, 0, 0, 0, 0, 0);

      ld_a(32'h00000021);
      bus_a.i_lap = 1'b1; ld_a(32'h00000077); bus_a.i_lap = 1'b0;
      chk(0, "lap_load", 32'h00000077, 32'h00000021, 1, 0, 0, 0, 0);

      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
